fmul_pipe: RTL
==============

FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter M_W, default 23, stored mantissa field width; BIT_W = 1+EXP_W+M_W is derived.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-007 SHALL have port a_in, input, BIT_W, IEEE-style operand A.
REQ-008 SHALL have port b_in, input, BIT_W, IEEE-style operand B.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port result, output, BIT_W, product.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent add; S2 (M_W+1)x(M_W+1) mantissa multiply; S3 normalise/round/pack.
REQ-013 SHALL transfer input when in_valid && in_ready; the result SHALL be valid 3 cycles later with no stall.
REQ-014 SHALL use a global stall = out_valid && !out_ready; in_ready = !stall; while stalled all stage registers, result and out_valid SHALL hold.
REQ-015 SHALL carry a valid bit per stage; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-016 SHALL keep result stable while out_valid && !out_ready.
REQ-017 SHALL compute sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-018 SHALL flush subnormal inputs (exp==0) to signed zero before the multiply.
REQ-019 SHALL return canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0) if either input is NaN, or for inf x zero.
REQ-020 SHALL return signed infinity if either input is infinite and the other is nonzero.
REQ-021 SHALL return signed zero if either input is zero (after flush) and the other is finite.
REQ-022 SHALL form the biased exponent as ea+eb-bias+norm with bias = 2^(EXP_W-1)-1, computed EXP_W+2 bits wide and signed.
REQ-023 SHALL round to nearest, ties to even, using guard and sticky bits over the full 2*(M_W+1)-bit product.
REQ-024 SHALL renormalise when rounding carries out of the mantissa (exponent +1).
REQ-025 SHALL return signed infinity when the final exponent >= 2^EXP_W-1 (overflow).
REQ-026 SHALL return signed zero when the final exponent <= 0 (underflow; no subnormal outputs).

Reset
REQ-027 SHALL clear all stage valid bits, out_valid=0 and result=0 while rst_n is low, independent of clk.
REQ-028 SHALL drop any in-flight operations at reset assertion; in_ready SHALL be 1 out of reset.
REQ-029 SHALL leave the datapath registers other than result uncleared (valid bits gate them).

Configuration
REQ-030 SHALL, with FMUL_PIPE_FLAGS_EN defined, add output flags[3:0] = {invalid, overflow, underflow, inexact}, aligned with and held alongside result, reset to 0.
REQ-031 SHALL set invalid for the NaN cases of REQ-019, overflow per REQ-025, underflow per REQ-026 or a flushed subnormal input, and inexact when guard|sticky is set, or on overflow/underflow.
REQ-032 SHALL, without FMUL_PIPE_FLAGS_EN, have no flags port and no flag logic; result behaviour SHALL be identical.

Verification
REQ-033 SHALL cover 3F800000 x 40000000 -> 40000000 with out_valid exactly 3 cycles after acceptance; BF800000 x 40000000 -> C0000000.
REQ-034 SHALL cover rounding: 3FC00000 x 3FC00000 -> 40100000; 3F800001 x 3F800001 -> 3F800002 (inexact=1 with flags).
REQ-035 SHALL cover specials: 7F7FFFFF x 7F7FFFFF -> 7F800000 (overflow); 00000001 x 00000001 -> 00000000 (underflow); 7F800000 x 00000000 -> 7FC00000 (invalid); 7F800000 x BF800000 -> FF800000.
REQ-036 SHALL cover back-pressure: stream 6 back-to-back ops, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 throughout, result held, all 6 results delivered in order with none lost or duplicated.
REQ-037 SHALL cover reset mid-operation: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately, no stale result after release, next op 3F800000 x 40400000 -> 40400000.

Source files
------------

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined IEEE-style multiplier with flush-to-zero and round-to-nearest-even.
// Define FMUL_PIPE_FLAGS_EN to add the flags[3:0] = {invalid, overflow, underflow, inexact} output.
module fmul_pipe #(
    parameter  int EXP_W = 8,
    parameter  int M_W   = 23,
    localparam int BIT_W = 1 + EXP_W + M_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIT_W-1:0] a_in,
    input  logic [BIT_W-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIT_W-1:0] result
`ifdef FMUL_PIPE_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int SIG_W     = M_W + 1;
    localparam int PROD_W    = 2 * SIG_W;
    localparam int XW        = EXP_W + 2;
    localparam int BIAS_I    = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX_I = (1 << EXP_W) - 1;

    localparam logic [BIT_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M_W-1){1'b0}}};

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: unpack / classify / exponent add ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [M_W-1:0]   a_man, b_man;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             nan_c, inf_c, zero_c;
    logic [XW-1:0]    exp_sum_c;

    assign {a_sign, a_exp, a_man} = a_in;
    assign {b_sign, b_exp, b_man} = b_in;

    // Exponent zero covers both true zeros and subnormals, which are flushed.
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);
    assign a_inf  = (&a_exp) & ~(|a_man);
    assign b_inf  = (&b_exp) & ~(|b_man);
    assign a_zero = ~(|a_exp);
    assign b_zero = ~(|b_exp);

    assign nan_c  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign inf_c  = (a_inf | b_inf) & ~nan_c;
    assign zero_c = (a_zero | b_zero) & ~nan_c & ~inf_c;

    assign exp_sum_c = XW'(a_exp) + XW'(b_exp) - XW'(BIAS_I);

    logic             s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [XW-1:0]    s1_exp;
    logic [SIG_W-1:0] s1_sig_a, s1_sig_b;

    // ---------------- S2: significand multiply ----------------
    logic              s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic [XW-1:0]     s2_exp;
    logic [PROD_W-1:0] s2_prod;

`ifdef FMUL_PIPE_FLAGS_EN
    logic sub_c, s1_sub, s2_sub;
    assign sub_c = (a_zero & (|a_man)) | (b_zero & (|b_man));
`endif

    // Datapath registers carry no reset; the stage valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign  <= a_sign ^ b_sign;
            s1_nan   <= nan_c;
            s1_inf   <= inf_c;
            s1_zero  <= zero_c;
            s1_exp   <= exp_sum_c;
            s1_sig_a <= {1'b1, a_man};
            s1_sig_b <= {1'b1, b_man};

            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_exp   <= s1_exp;
            s2_prod  <= PROD_W'(s1_sig_a) * PROD_W'(s1_sig_b);
`ifdef FMUL_PIPE_FLAGS_EN
            s1_sub   <= sub_c;
            s2_sub   <= s1_sub;
`endif
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic              norm_c;
    logic [PROD_W-2:0] norm_p;
    logic [M_W-1:0]    man_c;
    logic              guard_c, sticky_c, round_up;
    logic [M_W:0]      man_rnd;
    logic [XW-1:0]     exp_fin;
    logic              ovf, ufl;
    logic [BIT_W-1:0]  res_c;

    // Product lies in [1,4); the bits below the leading one form the fraction.
    assign norm_c   = s2_prod[PROD_W-1];
    assign norm_p   = norm_c ? s2_prod[PROD_W-2:0] : {s2_prod[PROD_W-3:0], 1'b0};
    assign man_c    = norm_p[PROD_W-2 -: M_W];
    assign guard_c  = norm_p[PROD_W-2-M_W];
    assign sticky_c = |norm_p[PROD_W-3-M_W:0];
    assign round_up = guard_c & (sticky_c | man_c[0]);
    assign man_rnd  = {1'b0, man_c} + (M_W+1)'(round_up);

    // A rounding carry leaves the fraction all-zero, so only the exponent moves.
    assign exp_fin = s2_exp + XW'(norm_c) + XW'(man_rnd[M_W]);
    assign ufl     = exp_fin[XW-1] | (exp_fin == '0);
    assign ovf     = ~exp_fin[XW-1] & (exp_fin >= XW'(EXP_MAX_I));

    always_comb begin
        res_c = {s2_sign, exp_fin[EXP_W-1:0], man_rnd[M_W-1:0]};
        if (s2_nan)
            res_c = QNAN;
        else if (s2_inf)
            res_c = {s2_sign, {EXP_W{1'b1}}, {M_W{1'b0}}};
        else if (s2_zero)
            res_c = {s2_sign, {(EXP_W+M_W){1'b0}}};
        else if (ovf)
            res_c = {s2_sign, {EXP_W{1'b1}}, {M_W{1'b0}}};
        else if (ufl)
            res_c = {s2_sign, {(EXP_W+M_W){1'b0}}};
    end

`ifdef FMUL_PIPE_FLAGS_EN
    logic [3:0] flags_c;

    always_comb begin
        flags_c = 4'b0000;
        if (s2_nan)
            flags_c[3] = 1'b1;
        else if (!s2_inf && !s2_zero) begin
            flags_c[2] = ovf;
            flags_c[1] = ufl;
            flags_c[0] = guard_c | sticky_c | ovf | ufl;
        end
        if (s2_sub) begin
            flags_c[1] = 1'b1;
            flags_c[0] = 1'b1;
        end
    end
`endif

    // Control and output registers; everything holds during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
`ifdef FMUL_PIPE_FLAGS_EN
            flags     <= 4'b0000;
`endif
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res_c;
`ifdef FMUL_PIPE_FLAGS_EN
                flags  <= flags_c;
`endif
            end
        end
    end

endmodule
